// File: rtl/snitch_tcdm_responder.sv
// snitch_tcdm_responder
//
// TCDM memory responder. It has a single request port and a
// fixed-latency response pipeline. Every accepted request produces
// exactly one response Latency cycles later. This holds for reads,
// writes, out-of-range requests and AMO requests. Initiators that
// count write responses as credits depend on this.
//
// Ports
//   clk_i       : clock; all state changes on the rising edge
//   rst_i       : synchronous, active-high reset. It clears the
//                 pipeline and the error flag. Storage is kept.
//   tcdm_req_i  : request (q_valid, q.addr/write/amo/data/strb/user)
//   tcdm_rsp_o  : grant and response (q_ready, p_valid, p.data)
//   busy_o      : high while any accepted request has not responded yet
//   err_o       : sticky flag. It is set the cycle after an out-of-range
//                 or AMO request is accepted.
//
// Optional feature
//   Define SNITCH_TCDM_RESPONDER_STALL_EN to inject pseudo-random
//   q_ready stalls. A 16-bit LFSR (seed 16'hACE1) drops q_ready
//   whenever its two low bits are zero.

package snitch_tcdm_responder_pkg;

   localparam logic [3:0] AMONone = 4'h0;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [3:0]  amo;
      logic [63:0] data;
      logic [7:0]  strb;
      logic        user;
   } tcdm_req_chan_t;

   typedef struct packed {
      tcdm_req_chan_t q;
      logic           q_valid;
   } tcdm_req_t;

   typedef struct packed {
      logic [63:0] data;
   } tcdm_rsp_chan_t;

   typedef struct packed {
      logic           q_ready;
      tcdm_rsp_chan_t p;
      logic           p_valid;
   } tcdm_rsp_t;

endpackage

module snitch_tcdm_responder #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned NumWords  = 512,
   parameter int unsigned Latency   = 1,
   parameter type tcdm_req_t = snitch_tcdm_responder_pkg::tcdm_req_t,
   parameter type tcdm_rsp_t = snitch_tcdm_responder_pkg::tcdm_rsp_t
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  tcdm_req_t tcdm_req_i,
   output tcdm_rsp_t tcdm_rsp_o,
   output logic      busy_o,
   output logic      err_o
);

   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned ByteOffs  = $clog2(StrbWidth);
   localparam int unsigned IdxWidth  = $clog2(NumWords);

   logic                 q_ready;
   logic                 accept;
   logic                 req_err;
   logic [AddrWidth-1:0] addr;
   logic [IdxWidth-1:0]  word_idx;
   logic                 mem_we;

   logic [DataWidth-1:0] mem_q [NumWords];

   logic [Latency-1:0]   valid_q, valid_d;
   logic [DataWidth-1:0] data_q [Latency];
   logic [DataWidth-1:0] data_d [Latency];
   logic                 err_q, err_d;

   // The user field carries no meaning for this responder.
   logic unused_user;
   assign unused_user = tcdm_req_i.q.user;

   // ------------------------------------------------------------------
   // Grant generation
   // ------------------------------------------------------------------
`ifdef SNITCH_TCDM_RESPONDER_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Fibonacci form, taps 16,14,13,11, shifting toward bit 0.
   always_comb begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      if (rst_i) begin
         lfsr_d = 16'hACE1;
      end
   end

   always_ff @(posedge clk_i) begin
      lfsr_q <= lfsr_d;
   end

   assign q_ready = ~rst_i & (lfsr_q[1:0] != 2'b00);
`else
   assign q_ready = ~rst_i;
`endif

   // ------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------
   assign accept   = tcdm_req_i.q_valid & q_ready;
   assign addr     = tcdm_req_i.q.addr;
   assign word_idx = addr[ByteOffs +: IdxWidth];
   // A request is an error if any address bit above the word index is
   // set, or if it asks for an atomic operation.
   assign req_err  = ((addr >> (ByteOffs + IdxWidth)) != '0) ||
                     (tcdm_req_i.q.amo != snitch_tcdm_responder_pkg::AMONone);
   assign mem_we   = accept & tcdm_req_i.q.write & ~req_err;

   // ------------------------------------------------------------------
   // Storage. It is not reset, and only enabled bytes are written.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < StrbWidth; b++) begin
            if (tcdm_req_i.q.strb[b]) begin
               mem_q[word_idx][8*b +: 8] <= tcdm_req_i.q.data[8*b +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Response pipeline
   // ------------------------------------------------------------------
   // Read data is captured before this edge's write lands. It therefore
   // reflects only writes accepted in earlier cycles.
   always_comb begin
      valid_d[0] = accept;
      data_d[0]  = (accept && !tcdm_req_i.q.write && !req_err) ?
                   mem_q[word_idx] : '0;
      for (int unsigned i = 1; i < Latency; i++) begin
         valid_d[i] = valid_q[i-1];
         data_d[i]  = data_q[i-1];
      end
      if (rst_i) begin
         valid_d = '0;
      end
   end

   always_comb begin
      err_d = err_q | (accept & req_err);
      if (rst_i) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int unsigned i = 0; i < Latency; i++) begin
         data_q[i] <= data_d[i];
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // The output stage is masked while reset is high. An in-flight
   // response then never appears during the first reset cycle, before
   // the flops have cleared.
   always_comb begin
      tcdm_rsp_o         = '0;
      tcdm_rsp_o.q_ready = q_ready;
      tcdm_rsp_o.p_valid = valid_q[Latency-1] & ~rst_i;
      tcdm_rsp_o.p.data  = (valid_q[Latency-1] && !rst_i) ?
                           data_q[Latency-1] : '0;
   end

   assign busy_o = |valid_q;
   assign err_o  = err_q;

endmodule

// File: tb/tb_snitch_tcdm_responder.sv
// Testbench for snitch_tcdm_responder.
// The driver pushes one expected response per accepted request. Each
// entry holds the data and the cycle the response is due. A
// negedge monitor pops an entry on every p_valid and checks it. The
// monitor also checks busy_o and err_o every cycle.

module tb_snitch_tcdm_responder;

   import snitch_tcdm_responder_pkg::*;

   localparam int unsigned LAT = 3;

   typedef struct {
      logic [63:0] data;
      int unsigned acc;   // negedge cycle at which the grant was seen
      int unsigned due;   // negedge cycle at which p_valid must appear
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   tcdm_req_t   req;
   tcdm_rsp_t   rsp;
   logic        busy;
   logic        err;

   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned failures = 0;
   int unsigned err_edge = 32'hFFFF_FFFF;
   int unsigned vcyc = 0;
   int unsigned stalls = 0;
   logic        in_reset = 1'b1;

   exp_t        sb[$];
   logic [63:0] mem_m [512];

   snitch_tcdm_responder #(
      .AddrWidth (32),
      .DataWidth (64),
      .NumWords  (512),
      .Latency   (LAT)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .tcdm_req_i (req),
      .tcdm_rsp_o (rsp),
      .busy_o     (busy),
      .err_o      (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic void chk(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference model. Storage is indexed by addr[11:3]. Any set bit in
   // addr[31:12], or a nonzero amo, marks an error request.
   function automatic void model_accept(input logic wr, input logic [31:0] a,
                                        input logic [63:0] d, input logic [7:0] s,
                                        input logic [3:0] amo);
      exp_t        e;
      logic        bad;
      int unsigned idx;
      bad = (a[31:12] != 20'd0) || (amo != 4'd0);
      idx = int'(a[11:3]);
      e.data = (!wr && !bad) ? mem_m[idx] : 64'd0;
      e.acc  = cyc;
      e.due  = cyc + LAT;
      if (wr && !bad) begin
         for (int b = 0; b < 8; b++) begin
            if (s[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
         end
      end
      if (bad && err_edge == 32'hFFFF_FFFF) err_edge = cyc + 1;
      sb.push_back(e);
   endfunction

   // Monitor
   always @(negedge clk) begin
      logic exp_busy;
      exp_t e;
      if (!in_reset) begin
         exp_busy = 1'b0;
         foreach (sb[i]) if (sb[i].acc < cyc && sb[i].due >= cyc) exp_busy = 1'b1;
         chk("busy", {63'd0, busy}, {63'd0, exp_busy});
         chk("err", {63'd0, err}, {63'd0, err_edge <= cyc});
`ifndef SNITCH_TCDM_RESPONDER_STALL_EN
         chk("q_ready", {63'd0, rsp.q_ready}, 64'd1);
`endif
         if (req.q_valid) begin
            vcyc++;
            if (!rsp.q_ready) stalls++;
         end
      end
      if (rsp.p_valid) begin
         if (sb.size() == 0) begin
            chk("spurious_p_valid", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("p_data", rsp.p.data, e.data);
            chk("p_time", 64'(cyc), 64'(e.due));
         end
      end else begin
         chk("p_data_idle", rsp.p.data, 64'd0);
         if (sb.size() != 0 && sb[0].due <= cyc) begin
            chk("missing_p_valid", 64'd0, 64'd1);
            void'(sb.pop_front());
         end
      end
   end

   task automatic idle();
      req.q_valid = 1'b0;
      req.q.user  = 1'($urandom);
   endtask

   // Holds the request until it is granted. The task returns 1 ns after
   // the accepting edge, so a back-to-back call follows with no gap.
   task automatic send(input logic wr, input logic [31:0] a, input logic [63:0] d,
                       input logic [7:0] s, input logic [3:0] amo);
      bit done = 1'b0;
      req.q_valid = 1'b1;
      req.q.write = wr;
      req.q.addr  = a;
      req.q.data  = d;
      req.q.strb  = s;
      req.q.amo   = amo;
      req.q.user  = 1'($urandom);
      for (int n = 0; n < 64 && !done; n++) begin
         @(negedge clk);
         if (rsp.q_ready) begin
            model_accept(wr, a, d, s, amo);
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!done) chk("grant_timeout", 64'd0, 64'd1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      in_reset = 1'b1;
      idle();
      sb.delete();
      err_edge = 32'hFFFF_FFFF;
      repeat (2) begin
         @(negedge clk);
         chk("rst_q_ready", {63'd0, rsp.q_ready}, 64'd0);
         chk("rst_p_valid", {63'd0, rsp.p_valid}, 64'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      in_reset = 1'b0;
      @(negedge clk);
      chk("post_rst_p_valid", {63'd0, rsp.p_valid}, 64'd0);
      chk("post_rst_busy", {63'd0, busy}, 64'd0);
      chk("post_rst_err", {63'd0, err}, 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      for (int n = 0; n < 64 && sb.size() != 0; n++) @(posedge clk);
      #1;
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      logic [31:0] a;
      logic        wr;
      logic [3:0]  amo;
      req = '0;
      do_reset();

      // Initialise the words the random phase will use.
      for (int i = 0; i < 32; i++) begin
         send(1'b1, 32'(i) << 3, {$urandom, $urandom}, 8'hFF, 4'd0);
      end
      idle();
      drain();

      // Full write, then read back.
      send(1'b1, 32'h8, 64'h1122_3344_5566_7788, 8'hFF, 4'd0);
      send(1'b0, 32'h8, 64'd0, 8'h00, 4'd0);
      idle();
      drain();
      chk("model_word1", mem_m[1], 64'h1122_3344_5566_7788);

      // Partial-strobe write over a zero word.
      send(1'b1, 32'h10, 64'd0, 8'hFF, 4'd0);
      send(1'b1, 32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 4'd0);
      send(1'b0, 32'h10, 64'd0, 8'h00, 4'd0);
      idle();
      drain();
      chk("model_word2", mem_m[2], 64'h0000_0000_FFFF_FFFF);

      // Eight back-to-back reads.
      for (int i = 0; i < 8; i++) send(1'b0, 32'(i) << 3, 64'd0, 8'h00, 4'd0);
      idle();
      drain();

      // Out-of-range read. err_o must stay sticky until reset.
      send(1'b0, 32'h1000, 64'd0, 8'h00, 4'd0);
      idle();
      repeat (10) @(posedge clk);
      #1;
      drain();

      // Reset one cycle after a read is accepted. The read must be dropped.
      send(1'b0, 32'h8, 64'd0, 8'h00, 4'd0);
      idle();
      do_reset();
      repeat (LAT + 2) @(posedge clk);
      #1;

      // Randomised traffic, including some error and AMO requests.
      for (int i = 0; i < 1000; i++) begin
         a   = {20'd0, 5'($urandom_range(0, 31)), 4'd0, 3'($urandom)};
         a[8:4] = 5'd0;
         a   = {20'd0, a[11:0]};
         a[11:3] = 9'($urandom_range(0, 31));
         if ($urandom_range(0, 15) == 0) a[12 + $urandom_range(0, 19)] = 1'b1;
         amo = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
         wr  = 1'($urandom);
         send(wr, a, {$urandom, $urandom}, 8'($urandom), amo);
         if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk); #1;
         end
      end
      idle();
      drain();

`ifdef SNITCH_TCDM_RESPONDER_STALL_EN
      checks++;
      if (stalls * 100 < vcyc * 15 || stalls * 100 > vcyc * 35) begin
         failures++;
         $display("FAIL stall_ratio: got %0d of %0d cycles stalled expected about 25%%",
                  stalls, vcyc);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/snitch_tcdm_responder.md
SNITCH_TCDM_RESPONDER -- requirements
Module: snitch_tcdm_responder

Interface
REQ-001: The module SHALL have parameter AddrWidth, default 32, meaning the request address width in bits.
REQ-002: The module SHALL have parameter DataWidth, default 64, meaning the data word width in bits (32 or 64).
REQ-003: The module SHALL have parameter NumWords, default 512, meaning the number of storage words (power of two, at least 2).
REQ-004: The module SHALL have parameter Latency, default 1, meaning the number of cycles from request acceptance to response (legal range 1..4).
REQ-005: The module SHALL have parameters tcdm_req_t and tcdm_rsp_t, default logic, meaning the TCDM request/response structs (q_valid, q{addr,write,amo,data,strb,user} / q_ready, p_valid, p{data}).
REQ-006: The module SHALL have port clk_i, input, 1 bit: the single clock; all state on rising edge.
REQ-007: The module SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-008: The module SHALL have port tcdm_req_i, input, tcdm_req_t: the incoming requests from the initiator (SSR or core).
REQ-009: The module SHALL have port tcdm_rsp_o, output, tcdm_rsp_t: the grant and response channel.
REQ-010: The module SHALL have port busy_o, output, 1 bit: high while any accepted request has not yet responded.
REQ-011: The module SHALL have port err_o, output, 1 bit: sticky error flag for out-of-range or AMO requests.

Function
REQ-012: A request SHALL be accepted in any cycle where q_valid and q_ready are both high; q_ready SHALL NOT depend combinationally on q_valid.
REQ-013: Word index = addr[log2(DataWidth/8) +: log2(NumWords)]; the request is out of range if any higher address bit is set.
REQ-014: An accepted in-range write with amo == AMONone SHALL update each byte whose strb bit is 1 at the acceptance clock edge; bytes with strb 0 SHALL be unchanged.
REQ-015: An accepted in-range read SHALL capture the word at acceptance, reflecting all writes accepted in earlier cycles only.
REQ-016: Every accepted request, read or write, SHALL produce exactly one p_valid pulse exactly Latency cycles after acceptance, because the initiator counts write responses as credits.
REQ-017: p.data SHALL carry the captured word for reads and SHALL be all-zero for writes and for error requests.
REQ-018: Responses SHALL have no backpressure; one response per cycle SHALL be sustainable with back-to-back acceptance, in strict acceptance order.
REQ-019: The response path SHALL be a Latency-deep valid/data shift pipeline; p_valid/p.data SHALL be 0 when the output stage is invalid.
REQ-020: Out-of-range or amo != AMONone requests SHALL be accepted, SHALL NOT modify storage, SHALL respond with zero data, and SHALL set err_o on the cycle after acceptance.
REQ-021: busy_o SHALL be the OR of all pipeline-stage valid bits.
REQ-022: Any q fields other than those above (user) SHALL be ignored.

Reset
REQ-023: While rst_i is high, all pipeline valid bits, err_o and busy_o SHALL clear at the next edge; p_valid SHALL be 0 during and in the cycle after reset.
REQ-024: Reset asserted mid-operation SHALL drop in-flight responses silently; storage contents SHALL NOT be reset.
REQ-025: Requests presented while rst_i is high SHALL NOT be accepted (q_ready = 0 during reset).

Configuration
REQ-026: Macro SNITCH_TCDM_RESPONDER_STALL_EN SHALL enable stall injection.
REQ-027: With the macro: a 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded to 16'hACE1 on reset and advances every cycle; q_ready = 0 when lfsr[1:0] == 2'b00, else 1.
REQ-028: Without the macro: q_ready = 1 whenever rst_i is low, and no LFSR exists.

Verification
REQ-029: Latency=1, write addr 0x8 data 0x1122334455667788 strb 0xFF, then read 0x8 -> write p_valid 1 cycle later with data 0, read p.data 0x1122334455667788.
REQ-030: Write strb 0x0F data all-ones over stored 0 at addr 0x10, read back -> 0x00000000FFFFFFFF.
REQ-031: Latency=3, 8 back-to-back reads -> 8 consecutive p_valid cycles starting 3 cycles after first acceptance, in order; busy_o high throughout, low after last.
REQ-032: NumWords=512, DataWidth=64, read addr 0x1000 -> zero-data response, err_o = 1 and stays 1 until rst_i.
REQ-033: Reset asserted 1 cycle after accepting a read with Latency=2 -> no p_valid ever emitted for it; busy_o = 0 after reset.
REQ-034: With SNITCH_TCDM_RESPONDER_STALL_EN, 1000 randomized requests with held q_valid -> responses match reference memory model, q_ready low ~25% of cycles, and no request lost or duplicated.
